spi_flash_responder: RTL and testbench

- Synthesizable SPI flash target (mode 0, MSB first). It emulates the flash device that our flash-to-cache loader reads at boot, so the loader can be exercised in simulation and on-board without a real flash part.
- It oversamples flash_clk/flash_cs/flash_mosi on its own system clock, decodes the command and 24-bit address, and streams bytes on flash_miso.
- Bytes are fetched from a byte-wide backing-store read port (BRAM or ROM image).

---
 rtl/spi_flash_responder_if.sv | 23 ++
 rtl/spi_flash_responder.sv | 175 +++++++++++++++++
 tb/tb_spi_flash_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI pins plus the byte-wide backing-store read port of the flash responder.
interface spi_flash_responder_if #(
    parameter int ADDRESS_BITWIDTH = 16
);
    logic                        flash_clk;
    logic                        flash_cs;
    logic                        flash_mosi;
    logic                        flash_miso;
    logic [ADDRESS_BITWIDTH-1:0] mem_addr;
    logic                        mem_rd_en;
    logic [7:0]                  mem_data;
    logic                        mem_data_valid;

    modport slave (
        input  flash_clk, flash_cs, flash_mosi, mem_data, mem_data_valid,
        output flash_miso, mem_addr, mem_rd_en
    );

    modport master (
        output flash_clk, flash_cs, flash_mosi, mem_data, mem_data_valid,
        input  flash_miso, mem_addr, mem_rd_en
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: oversampled pins, READ (0x03), JEDEC ID (0x9F) and STATUS (0x05).
module spi_flash_responder #(
    parameter int          ADDRESS_BITWIDTH = 16,
    parameter logic [23:0] JEDEC_ID         = 24'hEF4016
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_flash_responder_if.slave   bus,
    output logic                   busy,
    output logic                   underrun
);
    localparam int AW = ADDRESS_BITWIDTH;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STATUS, IGNORE} state_t;

    state_t        state;
    logic          sck_m, sck_s, sck_p;
    logic          cs_m, cs_s;
    logic          mosi_m, mosi_s;
    logic [4:0]    bit_count;
    logic [6:0]    shift_in;
    logic [AW-2:0] addr_shift;
    logic [7:0]    shift_out;
    logic [7:0]    prefetch;
    logic          prefetch_valid;
    logic [1:0]    id_idx;
    logic [1:0]    inflight;
    logic          miso_q;
    logic          rd_en_q;
    logic [AW-1:0] addr_q;

    logic          sck_rise, sck_fall;
    logic [7:0]    cmd_byte;
    logic [AW-1:0] addr_next;
    logic [7:0]    load_byte;
    logic          fetch_accept;

    assign sck_rise  = sck_s & ~sck_p;
    assign sck_fall  = ~sck_s & sck_p;
    assign cmd_byte  = {shift_in, mosi_s};
    assign addr_next = {addr_shift, mosi_s};

    // Only the response to the most recent request is kept; older ones still in flight are dropped.
    assign fetch_accept = bus.mem_data_valid && (inflight == 2'd1) && !rd_en_q;

    assign bus.flash_miso = miso_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_addr   = addr_q;

    always_comb begin
        load_byte = '0;
        case (state)
            DATA: load_byte = prefetch_valid ? prefetch : '1;
            ID: begin
                case (id_idx)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = '0;
                endcase
            end
            default: load_byte = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_m          <= 1'b0;
            sck_s          <= 1'b0;
            sck_p          <= 1'b0;
            cs_m           <= 1'b1;
            cs_s           <= 1'b1;
            mosi_m         <= 1'b0;
            mosi_s         <= 1'b0;
            state          <= IDLE;
            bit_count      <= '0;
            shift_in       <= '0;
            addr_shift     <= '0;
            shift_out      <= '0;
            prefetch       <= '0;
            prefetch_valid <= 1'b0;
            id_idx         <= '0;
            inflight       <= '0;
            miso_q         <= 1'b0;
            rd_en_q        <= 1'b0;
            addr_q         <= '0;
            busy           <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            sck_m  <= bus.flash_clk;
            sck_s  <= sck_m;
            sck_p  <= sck_s;
            cs_m   <= bus.flash_cs;
            cs_s   <= cs_m;
            mosi_m <= bus.flash_mosi;
            mosi_s <= mosi_m;

            rd_en_q <= 1'b0;
            busy    <= ~cs_s;

            case ({rd_en_q, bus.mem_data_valid})
                2'b10:   if (inflight != 2'd3) inflight <= inflight + 2'd1;
                2'b01:   if (inflight != 2'd0) inflight <= inflight - 2'd1;
                default: ;
            endcase

            if (fetch_accept) begin
                prefetch       <= bus.mem_data;
                prefetch_valid <= 1'b1;
            end

            // CS high wins over any SCK edge detected in the same cycle.
            if (cs_s) begin
                state          <= IDLE;
                bit_count      <= '0;
                shift_in       <= '0;
                addr_shift     <= '0;
                shift_out      <= '0;
                prefetch_valid <= 1'b0;
                miso_q         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= CMD;
                        bit_count <= '0;
                    end
                    CMD: if (sck_rise) begin
                        shift_in  <= cmd_byte[6:0];
                        bit_count <= bit_count + 5'd1;
                        if (bit_count == 5'd7) begin
                            bit_count <= '0;
                            id_idx    <= '0;
                            case (cmd_byte)
                                8'h03:   state <= ADDR;
                                8'h9F:   state <= ID;
                                8'h05:   state <= STATUS;
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr_shift <= addr_next[AW-2:0];
                        bit_count  <= bit_count + 5'd1;
                        if (bit_count == 5'd23) begin
                            addr_q         <= addr_next;
                            rd_en_q        <= 1'b1;
                            prefetch_valid <= 1'b0;
                            bit_count      <= '0;
                            state          <= DATA;
                        end
                    end
                    DATA, ID, STATUS: if (sck_fall) begin
                        bit_count <= {2'b00, bit_count[2:0] + 3'd1};
                        if (bit_count[2:0] == 3'd0) begin
                            // Byte start: drive MSB of the new byte and, in DATA, prefetch the following one.
                            miso_q    <= load_byte[7];
                            shift_out <= {load_byte[6:0], 1'b0};
                            if (state == DATA) begin
                                if (!prefetch_valid) underrun <= 1'b1;
                                prefetch_valid <= 1'b0;
                                addr_q         <= addr_q + AW'(1);
                                rd_en_q        <= 1'b1;
                            end
                            if (state == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end else begin
                            miso_q    <= shift_out[7];
                            shift_out <= {shift_out[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: SPI master at 8x clk ratio plus a variable-latency memory model.
module tb_spi_flash_responder;
    localparam int HALF = 40;

    logic clk;
    logic rst;
    logic busy;
    logic underrun;

    int   n_checks;
    int   n_errors;
    int   mem_lat;
    int   rd_count;
    logic [15:0] rd_log [0:63];
    logic [7:0]  mem [0:65535];
    logic [7:0]  rxbuf [0:15];
    logic        pipe_v [0:7];
    logic [7:0]  pipe_d [0:7];

    spi_flash_responder_if #(.ADDRESS_BITWIDTH(16)) bus ();

    spi_flash_responder #(
        .ADDRESS_BITWIDTH(16),
        .JEDEC_ID(24'hEF4016)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: a request seen at an edge is answered mem_lat cycles after the strobe cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pipe_v[i] = 1'b0;
                pipe_d[i] = 8'h00;
            end
        end else if (bus.mem_rd_en) begin
            rd_log[rd_count & 63] = bus.mem_addr;
            rd_count = rd_count + 1;
            pipe_v[mem_lat-1] = 1'b1;
            pipe_d[mem_lat-1] = mem[bus.mem_addr];
        end
        bus.mem_data_valid <= pipe_v[0];
        bus.mem_data       <= pipe_d[0];
        for (int i = 0; i < 7; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_d[i] = pipe_d[i+1];
        end
        pipe_v[7] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            bus.flash_mosi = tx[i];
            #(HALF);
            bus.flash_clk = 1'b1;
            rx[i] = bus.flash_miso;
            #(HALF);
            bus.flash_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        bus.flash_cs = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        bus.flash_cs = 1'b1;
        #30;
        check("busy_off", {31'd0, busy}, 32'd0);
        #70;
    endtask

    task automatic spi_cmd(input logic [7:0] cmd, input int n);
        logic [7:0] d;
        cs_low();
        spi_byte(cmd, d);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, d);
            rxbuf[k] = d;
        end
        check("busy_on", {31'd0, busy}, 32'd1);
        cs_high();
    endtask

    task automatic spi_read(input logic [23:0] addr, input int n);
        logic [7:0] d;
        cs_low();
        spi_byte(8'h03, d);
        spi_byte(addr[23:16], d);
        spi_byte(addr[15:8], d);
        spi_byte(addr[7:0], d);
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, d);
            rxbuf[k] = d;
        end
        check("busy_on", {31'd0, busy}, 32'd1);
        cs_high();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [31:0] word;
        int          base;

        n_checks = 0;
        n_errors = 0;
        mem_lat  = 2;
        rd_count = 0;
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
        rst            = 1'b1;
        bus.flash_cs   = 1'b1;
        bus.flash_clk  = 1'b0;
        bus.flash_mosi = 1'b0;
        repeat (4) @(posedge clk);
        #2;

        check("rst_miso", {31'd0, bus.flash_miso}, 32'd0);
        check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        check("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        #20;

        // Sequential read from 0
        base = rd_count;
        spi_read(24'h000000, 8);
        for (int k = 0; k < 8; k++) check($sformatf("read_b%0d", k), {24'd0, rxbuf[k]}, k);
        for (int k = 0; k < 8; k++) check($sformatf("read_addr%0d", k), {16'd0, rd_log[(base + k) & 63]}, k);
        check("read_rd_cnt", {31'd0, (rd_count - base) >= 8}, 32'd1);
        check("read_underrun", {31'd0, underrun}, 32'd0);

        // Little-endian word assembly
        mem[0] = 8'hCD; mem[1] = 8'hAB; mem[2] = 8'h34; mem[3] = 8'h12;
        spi_read(24'h000000, 4);
        word = {rxbuf[3], rxbuf[2], rxbuf[1], rxbuf[0]};
        check("le_word", word, 32'h1234ABCD);

        // Address wrap at 0xFFFF
        mem[16'hFFFE] = 8'hAA; mem[16'hFFFF] = 8'hBB; mem[0] = 8'h11; mem[1] = 8'h22;
        base = rd_count;
        spi_read(24'h00FFFE, 4);
        check("wrap_b0", {24'd0, rxbuf[0]}, 32'hAA);
        check("wrap_b1", {24'd0, rxbuf[1]}, 32'hBB);
        check("wrap_b2", {24'd0, rxbuf[2]}, 32'h11);
        check("wrap_b3", {24'd0, rxbuf[3]}, 32'h22);
        check("wrap_a0", {16'd0, rd_log[base & 63]}, 32'hFFFE);
        check("wrap_a1", {16'd0, rd_log[(base + 1) & 63]}, 32'hFFFF);
        check("wrap_a2", {16'd0, rd_log[(base + 2) & 63]}, 32'h0000);
        check("wrap_a3", {16'd0, rd_log[(base + 3) & 63]}, 32'h0001);

        // JEDEC ID, unknown command, status
        spi_cmd(8'h9F, 4);
        check("id_b0", {24'd0, rxbuf[0]}, 32'hEF);
        check("id_b1", {24'd0, rxbuf[1]}, 32'h40);
        check("id_b2", {24'd0, rxbuf[2]}, 32'h16);
        check("id_b3", {24'd0, rxbuf[3]}, 32'h00);
        spi_cmd(8'hAB, 2);
        check("ign_b0", {24'd0, rxbuf[0]}, 32'h00);
        check("ign_b1", {24'd0, rxbuf[1]}, 32'h00);
        spi_cmd(8'h05, 2);
        check("stat_b0", {24'd0, rxbuf[0]}, 32'h00);
        check("stat_b1", {24'd0, rxbuf[1]}, 32'h00);

        // Abort mid-byte, then a fresh read
        for (int i = 0; i < 32; i++) mem[i] = i[7:0];
        mem[16'h20] = 8'hA5; mem[16'h21] = 8'hFF;
        cs_low();
        spi_byte(8'h03, d); spi_byte(8'h00, d); spi_byte(8'h00, d); spi_byte(8'h20, d);
        spi_byte(8'h00, d);
        check("abort_b0", {24'd0, d}, 32'hA5);
        spi_bits(8'h00, 3, d);
        check("abort_part", {24'd0, d}, 32'hE0);
        #(HALF);
        check("abort_pre_miso", {31'd0, bus.flash_miso}, 32'd1);
        cs_high();
        check("abort_miso", {31'd0, bus.flash_miso}, 32'd0);
        spi_read(24'h000010, 2);
        check("abort_new_b0", {24'd0, rxbuf[0]}, 32'h10);
        check("abort_new_b1", {24'd0, rxbuf[1]}, 32'h11);

        // Reset in the middle of the address phase
        cs_low();
        spi_byte(8'h03, d); spi_byte(8'h12, d);
        spi_bits(8'h34, 4, d);
        check("midrst_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #20;
        check("midrst_miso", {31'd0, bus.flash_miso}, 32'd0);
        check("midrst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        check("midrst_addr", {16'd0, bus.mem_addr}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_underrun", {31'd0, underrun}, 32'd0);
        bus.flash_cs = 1'b1;
        #40;
        rst = 1'b0;
        #60;

        // Slow memory: first byte misses its deadline
        mem_lat = 6;
        spi_read(24'h000000, 2);
        check("under_b0", {24'd0, rxbuf[0]}, 32'hFF);
        check("under_b1", {24'd0, rxbuf[1]}, 32'h01);
        check("under_flag", {31'd0, underrun}, 32'd1);
        #200;
        check("under_sticky", {31'd0, underrun}, 32'd1);
        rst = 1'b1;
        #20;
        check("under_clr", {31'd0, underrun}, 32'd0);
        rst = 1'b0;
        #20;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
